// File: rtl/regfile_pkg.sv
// Shared constants for the bypassing register file.
// Holds the default geometry (data width, address width, read-port count).
// It also provides helpers that size the packed read-address bus, the
// packed read-data bus and the pending counter from that geometry.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    // Width of the packed read-address bus: NUM_RD slots of ADDR_W bits.
    function automatic int unsigned ra_bus_w(input int unsigned addr_w, input int unsigned num_rd);
        return addr_w * num_rd;
    endfunction

    // Width of the packed read-data bus: NUM_RD slots of DATA_W bits.
    function automatic int unsigned rd_bus_w(input int unsigned data_w, input int unsigned num_rd);
        return data_w * num_rd;
    endfunction

    // The pending count must reach DEPTH = 2**addr_w without wrapping.
    function automatic int unsigned cnt_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// Bus bundle for regfile_bypass.
// It carries the write port (we/rw/wd), the packed read ports (ra/rd), the
// claim port (claim_en/claim_addr) and the hazard status outputs
// (busy/hazard/pend_cnt).
// The master modport drives requests; the slave modport is the register file.
interface regfile_bypass_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
);

    logic                                  we;
    logic [ADDR_W-1:0]                     rw;
    logic [DATA_W-1:0]                     wd;
    logic [ra_bus_w(ADDR_W, NUM_RD)-1:0]   ra;
    logic [rd_bus_w(DATA_W, NUM_RD)-1:0]   rd;
    logic                                  claim_en;
    logic [ADDR_W-1:0]                     claim_addr;
    logic [NUM_RD-1:0]                     busy;
    logic                                  hazard;
    logic [cnt_w(ADDR_W)-1:0]              pend_cnt;

    modport master (
        output we, rw, wd, ra, claim_en, claim_addr,
        input  rd, busy, hazard, pend_cnt
    );

    modport slave (
        input  we, rw, wd, ra, claim_en, claim_addr,
        output rd, busy, hazard, pend_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-register scoreboard for regfile_bypass.
// It keeps one pend bit per register. A claim sets the bit and a write clears
// it; when both target the same register, the claim wins.
// Ports: clk, rst (async, active high); we_i/rw_i write port;
// claim_en_i/claim_addr_i claim port; ra_i packed read addresses;
// busy_o per read port; pend_cnt_o registered population count.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned ZERO_REG = 1
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we_i,
    input  logic [ADDR_W-1:0]                   rw_i,
    input  logic                                claim_en_i,
    input  logic [ADDR_W-1:0]                   claim_addr_i,
    input  logic [ra_bus_w(ADDR_W, NUM_RD)-1:0] ra_i,
    output logic [NUM_RD-1:0]                   busy_o,
    output logic [cnt_w(ADDR_W)-1:0]            pend_cnt_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = cnt_w(ADDR_W);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The release is applied before the claim, so a same-cycle claim of the
    // written register leaves it pending for the new producer.
    always_comb begin
        pend_d = pend_q;
        if (we_i) begin
            pend_d[rw_i] = 1'b0;
        end
        if (claim_en_i) begin
            pend_d[claim_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
        // The count is taken from the post-edge pend bits, so it reaches
        // DEPTH at most and never wraps.
        cnt_d = CNT_W'($countones(pend_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // A write in the same cycle releases the hazard, because the bypass
    // already delivers the new value.
    always_comb begin
        busy_o = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] ra_p;
            ra_p      = ra_i[p*ADDR_W +: ADDR_W];
            busy_o[p] = !rst && pend_q[ra_p] && !(we_i && (rw_i == ra_p));
        end
    end

    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_bypass.sv
// Multi-read-port register file with write-first bypass and hazard
// scoreboard.
// Ports: clk (rising edge), rst (async, active high), and bus (slave
// modport of regfile_bypass_if).
// The bus carries the write port, the packed read ports, the claim port,
// busy/hazard and pend_cnt.
// ZERO_REG=1 hardwires register 0 to zero and makes it unclaimable.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned ZERO_REG = 1
)(
    input  logic            clk,
    input  logic            rst,
    regfile_bypass_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en;

    always_comb begin
        wr_en = bus.we && !((ZERO_REG != 0) && (bus.rw == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.rw] <= bus.wd;
        end
    end

    // Read priority: reset, then the hardwired zero, then the write bypass,
    // then storage.
    always_comb begin
        bus.rd = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] ra_p;
            logic [DATA_W-1:0] rd_p;
            ra_p = bus.ra[p*ADDR_W +: ADDR_W];
            if (rst) begin
                rd_p = '0;
            end else if ((ZERO_REG != 0) && (ra_p == '0)) begin
                rd_p = '0;
            end else if (bus.we && (bus.rw == ra_p)) begin
                rd_p = bus.wd;
            end else begin
                rd_p = regs_q[ra_p];
            end
            bus.rd[p*DATA_W +: DATA_W] = rd_p;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .we_i         (bus.we),
        .rw_i         (bus.rw),
        .claim_en_i   (bus.claim_en),
        .claim_addr_i (bus.claim_addr),
        .ra_i         (bus.ra),
        .busy_o       (bus.busy),
        .pend_cnt_o   (bus.pend_cnt)
    );

    assign bus.hazard = |bus.busy;

endmodule
